// File: rtl/encap_packet.sv
// encap_packet: splits one {addr, data} transfer into a fixed train of link beats.
// Optional ENCAP_BUSY_OUT_EN adds the encap_busy output.
module encap_packet #(
  parameter int DATA_WIDTH             = 1024,
  parameter int ADDR_WIDTH             = 10,
  parameter int DATA_DFX_WIDTH         = DATA_WIDTH + ADDR_WIDTH,
  parameter int RECOGNIZE_ROUTER_WIDTH = 2,
  parameter int NUMBER_PACKET          = 19,
  parameter int TTL_WIDTH              = 2,
  parameter int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH
                                         + $clog2(NUMBER_PACKET)
                                         + TTL_WIDTH,
  parameter int AURORA_DATA_WIDTH      = 64,
  parameter int PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        data_arbiter_send,
  input  logic [ADDR_WIDTH-1:0]        router_dst_addr_send,
  input  logic [HEADER_WIDTH-1:0]      header_pkt_send,
  input  logic                         start_encap_pkt,
  output logic [AURORA_DATA_WIDTH-1:0] data_send,
  output logic                         data_encap_valid,
  output logic                         encap_done
`ifdef ENCAP_BUSY_OUT_EN
  ,
  output logic                         encap_busy
`endif
);

  localparam int SEQ_W = $clog2(NUMBER_PACKET);
  localparam int PAD_W = NUMBER_PACKET * PAYLOAD_WIDTH;
  localparam int RR_W  = RECOGNIZE_ROUTER_WIDTH;
  localparam logic [SEQ_W-1:0] LAST = SEQ_W'(NUMBER_PACKET - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                         state_q, state_d;
  logic [SEQ_W-1:0]               k_q, k_d;
  logic [PAD_W-1:0]               buf_q, buf_d;
  logic [RR_W-1:0]                rec_q, rec_d;
  logic [TTL_WIDTH-1:0]           ttl_q, ttl_d;
  logic [AURORA_DATA_WIDTH-1:0]   data_d;
  logic                           valid_d;
  logic                           done_d;

  // The sequence field of the template is replaced by the beat index.
  logic seq_unused;
  assign seq_unused = ^header_pkt_send[HEADER_WIDTH-RR_W-1:TTL_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      k_q              <= '0;
      buf_q            <= '0;
      rec_q            <= '0;
      ttl_q            <= '0;
      data_send        <= '0;
      data_encap_valid <= 1'b0;
      encap_done       <= 1'b0;
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      buf_q            <= buf_d;
      rec_q            <= rec_d;
      ttl_q            <= ttl_d;
      data_send        <= data_d;
      data_encap_valid <= valid_d;
      encap_done       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    buf_d   = buf_q;
    rec_d   = rec_q;
    ttl_d   = ttl_q;
    data_d  = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Last beat is still on the wire here: a start now is dropped.
        if (start_encap_pkt && !data_encap_valid) begin
          state_d = SEND;
          k_d     = '0;
          buf_d   = '0;
          buf_d[DATA_DFX_WIDTH-1:0] = {router_dst_addr_send,
                                       data_arbiter_send};
          rec_d   = header_pkt_send[HEADER_WIDTH-1 -: RR_W];
          ttl_d   = header_pkt_send[TTL_WIDTH-1:0];
        end
      end
      SEND: begin
        data_d  = {rec_q, k_q, ttl_q, buf_q[PAYLOAD_WIDTH-1:0]};
        valid_d = 1'b1;
        done_d  = (k_q == LAST);
        buf_d   = buf_q >> PAYLOAD_WIDTH;
        k_d     = k_q + 1'b1;
        if (k_q == LAST) begin
          state_d = IDLE;
          k_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ENCAP_BUSY_OUT_EN
  assign encap_busy = data_encap_valid;
`endif

endmodule

// File: tb/tb_encap_packet.sv
// tb_encap_packet: directed bench for encap_packet.
// Hand-computed beats plus a slice model of the padded transfer.
module tb_encap_packet;

  logic          clk = 1'b0;
  logic          rst;
  logic [1023:0] data_arbiter_send;
  logic [9:0]    router_dst_addr_send;
  logic [8:0]    header_pkt_send;
  logic          start_encap_pkt;
  logic [63:0]   data_send;
  logic          data_encap_valid;
  logic          encap_done;
`ifdef ENCAP_BUSY_OUT_EN
  logic          encap_busy;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  encap_packet dut (
    .clk                  (clk),
    .rst                  (rst),
    .data_arbiter_send    (data_arbiter_send),
    .router_dst_addr_send (router_dst_addr_send),
    .header_pkt_send      (header_pkt_send),
    .start_encap_pkt      (start_encap_pkt),
    .data_send            (data_send),
    .data_encap_valid     (data_encap_valid),
    .encap_done           (encap_done)
`ifdef ENCAP_BUSY_OUT_EN
    ,
    .encap_busy           (encap_busy)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 64'(data_encap_valid), 64'd0);
    check({tag, ".data"}, data_send, 64'd0);
    check({tag, ".done"}, 64'(encap_done), 64'd0);
`ifdef ENCAP_BUSY_OUT_EN
    check({tag, ".busy"}, 64'(encap_busy), 64'd0);
`endif
  endtask

  function automatic logic [1044:0] pad(input logic [1023:0] d,
                                        input logic [9:0] a);
    pad = {11'd0, a, d};
  endfunction

  function automatic logic [63:0] beat(input logic [1044:0] p,
                                       input logic [8:0] h, input int k);
    logic [4:0] kk;
    kk = 5'(k);
    beat = {h[8:7], kk, h[1:0], p[k*55 +: 55]};
  endfunction

  // Pulse start for one cycle, then scramble the inputs.
  task automatic pulse_start(input logic [1023:0] d, input logic [9:0] a,
                             input logic [8:0] h);
    data_arbiter_send    = d;
    router_dst_addr_send = a;
    header_pkt_send      = h;
    start_encap_pkt      = 1'b1;
    @(negedge clk);
    start_encap_pkt      = 1'b0;
    check("pre_beat.valid", 64'(data_encap_valid), 64'd0);
    data_arbiter_send    = ~d;
    router_dst_addr_send = ~a;
    header_pkt_send      = ~h;
  endtask

  // Checks all beats and the idle cycle after; optional start poke.
  task automatic expect_train(input logic [1044:0] p, input logic [8:0] h,
                              input int poke);
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      start_encap_pkt = 1'b0;
      check($sformatf("beat%0d.valid", k), 64'(data_encap_valid), 64'd1);
      check($sformatf("beat%0d.data", k), data_send, beat(p, h, k));
      check($sformatf("beat%0d.done", k), 64'(encap_done),
            64'(k == 18));
`ifdef ENCAP_BUSY_OUT_EN
      check($sformatf("beat%0d.busy", k), 64'(encap_busy), 64'd1);
`endif
      if (k == poke) begin
        data_arbiter_send = {32{32'hDEADBEEF}};
        header_pkt_send   = 9'h1FF;
        start_encap_pkt   = 1'b1;
      end
    end
    @(negedge clk);
    start_encap_pkt = 1'b0;
    check_idle("after_train");
  endtask

  logic [255:0]  blk;
  logic [1023:0] d0, d1, d2;
  logic [1044:0] p0;
  logic [8:0]    h0;

  initial begin
    blk = 256'h11111111222222223333333344444444_55555555666666667777777788888888;
    d0  = {4{blk}};
    h0  = 9'b10_00100_01;
    p0  = pad(d0, 10'h001);
    for (int i = 0; i < 32; i++) begin
      d1[i*32 +: 32] = 32'hA5A50000 + 32'(i);
      d2[i*32 +: 32] = $urandom;
    end

    rst                  = 1'b1;
    start_encap_pkt      = 1'b1;
    data_arbiter_send    = d0;
    router_dst_addr_send = 10'h3FF;
    header_pkt_send      = h0;
    @(negedge clk);
    check_idle("reset0");
    @(negedge clk);
    check_idle("reset1");
    start_encap_pkt = 1'b0;
    rst             = 1'b0;
    @(negedge clk);
    check_idle("idle");

    // Basic train with hand-computed end beats.
    pulse_start(d0, 10'h001, h0);
    @(negedge clk);
    check("basic.beat0", data_send, 64'h80F7777788888888);
    check("basic.beat0_done", 64'(encap_done), 64'd0);
    for (int k = 1; k < 18; k++) begin
      @(negedge clk);
      check($sformatf("seq%0d", k), 64'(data_send[63:55]),
            64'({2'b10, 5'(k), 2'b01}));
    end
    @(negedge clk);
    check("basic.beat18", data_send, 64'hA480000444444444);
    check("basic.beat18_done", 64'(encap_done), 64'd1);
    @(negedge clk);
    check_idle("basic.after");

    // Full model check; start during beat 5 must be ignored.
    @(negedge clk);
    pulse_start(d0, 10'h001, h0);
    expect_train(p0, h0, 5);
    repeat (2) begin
      @(negedge clk);
      check_idle("busy_poke.quiet");
    end

    // Start sampled on the edge ending beat 18 is dropped.
    pulse_start(d1, 10'h2AB, 9'b01_11111_10);
    expect_train(pad(d1, 10'h2AB), 9'b01_11111_10, 18);
    repeat (3) begin
      @(negedge clk);
      check_idle("last_beat_poke.quiet");
    end

    // Reset during beat 10 abandons the train.
    pulse_start(d1, 10'h155, 9'b11_00000_11);
    for (int k = 0; k <= 10; k++) @(negedge clk);
    check("mid.beat10", data_send, beat(pad(d1, 10'h155), 9'b11_00000_11, 10));
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid.reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle("mid.quiet");
    end
    pulse_start(d0, 10'h001, h0);
    expect_train(p0, h0, -1);

    // Back-to-back: start on the first cycle after beat 18.
    pulse_start(d2, 10'h0F0, 9'b00_01010_10);
    @(negedge clk);
    check("b2b.first_beat0", data_send,
          beat(pad(d2, 10'h0F0), 9'b00_01010_10, 0));
    for (int k = 1; k < 19; k++) @(negedge clk);
    check("b2b.first_done", 64'(encap_done), 64'd1);
    @(negedge clk);
    check_idle("b2b.gap");
    pulse_start(d1, 10'h00F, h0);
    expect_train(pad(d1, 10'h00F), h0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
